// File: rtl/plic_pkg.sv
// Shared constants and gateway state encoding for the PLIC core.
package plic_pkg;
    localparam int ID_W    = 6;   // wide enough for IDs 0..63
    localparam int MAX_SRC = 63;
    localparam int MAX_TGT = 4;

    typedef enum logic {
        GW_IDLE     = 1'b0,
        GW_INFLIGHT = 1'b1
    } gw_state_e;
endpackage

// File: rtl/plic_gateway_cell.sv
// Per-source interrupt gateway: turns a level or rising-edge line into at
// most one outstanding request, held until the matching completion.
module plic_gateway_cell
    import plic_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic irq,
    input  logic edge_mode,
    input  logic cmpl,
    output logic fwd,
    output logic inflight
);
    gw_state_e state_reg;
    logic      irq_d_reg;
    logic      missed_reg;
    logic      rise;

    assign rise     = irq & ~irq_d_reg;
    assign inflight = (state_reg == GW_INFLIGHT);

    // Forward a request only from IDLE; a remembered edge counts as a request.
    always_comb begin
        fwd = 1'b0;
        if (state_reg == GW_IDLE) begin
            fwd = edge_mode ? (rise | missed_reg) : irq;
        end
    end

    // Gateway FSM, edge delay flop and the single-entry missed-edge memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= GW_IDLE;
            irq_d_reg  <= 1'b0;
            missed_reg <= 1'b0;
        end else begin
            irq_d_reg <= irq;
            case (state_reg)
                GW_IDLE: begin
                    // Any remembered edge is consumed by this cycle's forward.
                    missed_reg <= 1'b0;
                    if (fwd) begin
                        state_reg <= GW_INFLIGHT;
                    end
                end
                default: begin
                    if (edge_mode && rise) begin
                        missed_reg <= 1'b1;
                    end
                    if (cmpl) begin
                        state_reg <= GW_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/plic_multi_target_core.sv
// Multi-target PLIC core: gateways, pending register, per-target
// priority arbitration, claim and completion handling.
module plic_multi_target_core
    import plic_pkg::*;
#(
    parameter int NUM_SRC = 31,
    parameter int NUM_TGT = 3,
    parameter int PRIO_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_irq,
    input  logic [NUM_SRC-1:0]        src_edge,
    input  logic [NUM_SRC*PRIO_W-1:0] src_prio,
    input  logic [NUM_TGT*NUM_SRC-1:0] tgt_en,
    input  logic [NUM_TGT*PRIO_W-1:0] tgt_thresh,
    input  logic [NUM_TGT-1:0]        claim_req,
    output logic [NUM_TGT*ID_W-1:0]   claim_id,
    output logic [NUM_TGT-1:0]        claim_vld,
    input  logic [NUM_TGT-1:0]        cmpl_req,
    input  logic [NUM_TGT*ID_W-1:0]   cmpl_id,
    output logic [NUM_SRC:0]          pending,
    output logic [NUM_TGT-1:0]        eip
);
    logic [NUM_SRC:1]        pending_reg;
    logic [NUM_SRC:1]        fwd;
    logic [NUM_SRC:1]        inflight;
    logic [NUM_SRC:1]        cmpl_hit;
    logic [NUM_SRC:1]        claim_clr;
    logic [NUM_TGT*ID_W-1:0] best_flat;
    logic [NUM_TGT*ID_W-1:0] grant_flat;
    logic [NUM_TGT-1:0]      eip_reg;
    logic [NUM_TGT-1:0]      claim_vld_reg;
    logic [NUM_TGT*ID_W-1:0] claim_id_reg;

    genvar gi;

    generate
        for (gi = 1; gi <= NUM_SRC; gi++) begin : g_gw
            plic_gateway_cell u_gw (
                .clk       (clk),
                .rst       (rst),
                .irq       (src_irq[gi-1]),
                .edge_mode (src_edge[gi-1]),
                .cmpl      (cmpl_hit[gi]),
                .fwd       (fwd[gi]),
                .inflight  (inflight[gi])
            );
        end

        for (gi = 0; gi < NUM_TGT; gi++) begin : g_arb
            logic [ID_W-1:0]   best;
            logic [PRIO_W-1:0] best_prio;

            // Highest eligible priority wins; strict compare keeps the lowest ID on ties.
            always_comb begin
                best      = '0;
                best_prio = '0;
                for (int i = 1; i <= NUM_SRC; i++) begin
                    if (pending_reg[i] && tgt_en[gi*NUM_SRC + i - 1] &&
                        (src_prio[(i-1)*PRIO_W +: PRIO_W] > tgt_thresh[gi*PRIO_W +: PRIO_W]) &&
                        (src_prio[(i-1)*PRIO_W +: PRIO_W] > best_prio)) begin
                        best_prio = src_prio[(i-1)*PRIO_W +: PRIO_W];
                        best      = ID_W'(i);
                    end
                end
            end

            assign best_flat[gi*ID_W +: ID_W] = best;
        end
    endgenerate

    // Claim grants: a lower-index target claiming the same ID takes it, others get 0.
    always_comb begin
        grant_flat = '0;
        claim_clr  = '0;
        for (int t = 0; t < NUM_TGT; t++) begin
            logic [ID_W-1:0] g;
            g = '0;
            if (claim_req[t]) begin
                g = best_flat[t*ID_W +: ID_W];
                for (int u = 0; u < t; u++) begin
                    if (claim_req[u] && (best_flat[u*ID_W +: ID_W] == g)) begin
                        g = '0;
                    end
                end
            end
            grant_flat[t*ID_W +: ID_W] = g;
            for (int i = 1; i <= NUM_SRC; i++) begin
                if (g == ID_W'(i)) begin
                    claim_clr[i] = 1'b1;
                end
            end
        end
    end

    // Completions only count for an in-flight source enabled for the completing target.
    always_comb begin
        cmpl_hit = '0;
        for (int t = 0; t < NUM_TGT; t++) begin
            for (int i = 1; i <= NUM_SRC; i++) begin
                if (cmpl_req[t] && (cmpl_id[t*ID_W +: ID_W] == ID_W'(i)) &&
                    inflight[i] && tgt_en[t*NUM_SRC + i - 1]) begin
                    cmpl_hit[i] = 1'b1;
                end
            end
        end
    end

    // Pending set by forwards, cleared by claims (claim wins), plus registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg   <= '0;
            eip_reg       <= '0;
            claim_vld_reg <= '0;
            claim_id_reg  <= '0;
        end else begin
            pending_reg   <= (pending_reg | fwd) & ~claim_clr;
            claim_vld_reg <= claim_req;
            for (int t = 0; t < NUM_TGT; t++) begin
                eip_reg[t] <= (best_flat[t*ID_W +: ID_W] != '0);
                if (claim_req[t]) begin
                    claim_id_reg[t*ID_W +: ID_W] <= grant_flat[t*ID_W +: ID_W];
                end
            end
        end
    end

    assign pending   = {pending_reg, 1'b0};
    assign eip       = eip_reg;
    assign claim_vld = claim_vld_reg;
    assign claim_id  = claim_id_reg;
endmodule

// File: tb/tb_plic_multi_target_core.sv
// Scenario bench for the multi-target PLIC core with a claim scoreboard.
module tb_plic_multi_target_core;
    localparam int NS = 31;
    localparam int NT = 3;
    localparam int PW = 5;
    localparam int IW = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     src_irq;
    logic [NS-1:0]     src_edge;
    logic [NS*PW-1:0]  src_prio;
    logic [NT*NS-1:0]  tgt_en;
    logic [NT*PW-1:0]  tgt_thresh;
    logic [NT-1:0]     claim_req;
    logic [NT*IW-1:0]  claim_id;
    logic [NT-1:0]     claim_vld;
    logic [NT-1:0]     cmpl_req;
    logic [NT*IW-1:0]  cmpl_id;
    logic [NS:0]       pending;
    logic [NT-1:0]     eip;

    typedef struct {
        int tgt;
        int id;
    } claim_t;

    claim_t sb[$];
    int     n_cmp = 0;
    int     n_err = 0;

    plic_multi_target_core #(.NUM_SRC(NS), .NUM_TGT(NT), .PRIO_W(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_irq    (src_irq),
        .src_edge   (src_edge),
        .src_prio   (src_prio),
        .tgt_en     (tgt_en),
        .tgt_thresh (tgt_thresh),
        .claim_req  (claim_req),
        .claim_id   (claim_id),
        .claim_vld  (claim_vld),
        .cmpl_req   (cmpl_req),
        .cmpl_id    (cmpl_id),
        .pending    (pending),
        .eip        (eip)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_prio(input int i, input int p);
        src_prio[(i-1)*PW +: PW] = PW'(p);
    endtask

    task automatic set_en(input int t, input int i);
        tgt_en[t*NS + i - 1] = 1'b1;
    endtask

    task automatic expect_claim(input int t, input int id);
        claim_t e;
        e.tgt = t;
        e.id  = id;
        sb.push_back(e);
    endtask

    // Pulse claims, then pop one scoreboard entry per claim_vld strobe.
    task automatic issue_claims(input logic [NT-1:0] mask);
        claim_t e;
        claim_req = mask;
        step(1);
        claim_req = '0;
        for (int t = 0; t < NT; t++) begin
            if (claim_vld[t]) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL claim_unexpected tgt=%0d got_id=%0d want=no strobe", t, claim_id[t*IW +: IW]);
                end else begin
                    e = sb.pop_front();
                    $display("claim tgt=%0d id=%0d", t, claim_id[t*IW +: IW]);
                    if (e.tgt != t || claim_id[t*IW +: IW] !== IW'(e.id)) begin
                        n_err++;
                        $display("FAIL claim_id got tgt=%0d id=%0d want tgt=%0d id=%0d",
                                 t, claim_id[t*IW +: IW], e.tgt, e.id);
                    end
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL claim_missing got=%0d strobes outstanding want=0", sb.size());
        end
        sb.delete();
    endtask

    task automatic complete(input int t, input int id);
        cmpl_req[t] = 1'b1;
        cmpl_id[t*IW +: IW] = IW'(id);
        step(1);
        cmpl_req = '0;
        cmpl_id  = '0;
        $display("complete tgt=%0d id=%0d", t, id);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        n_cmp++; if (pending !== '0) begin n_err++; $display("FAIL reset_pending got=%h want=0", pending); end
        n_cmp++; if (eip !== '0) begin n_err++; $display("FAIL reset_eip got=%b want=0", eip); end
        n_cmp++; if (claim_vld !== '0) begin n_err++; $display("FAIL reset_claim_vld got=%b want=0", claim_vld); end
        n_cmp++; if (claim_id !== '0) begin n_err++; $display("FAIL reset_claim_id got=%h want=0", claim_id); end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_level();
        set_prio(3, 2);
        set_en(0, 3);
        src_irq[2] = 1'b1;
        step(1);
        n_cmp++; if (pending[3] !== 1'b1) begin n_err++; $display("FAIL lvl_pend got=%b want=1", pending[3]); end
        n_cmp++; if (eip[0] !== 1'b0) begin n_err++; $display("FAIL lvl_eip_early got=%b want=0", eip[0]); end
        step(1);
        n_cmp++; if (eip[0] !== 1'b1) begin n_err++; $display("FAIL lvl_eip got=%b want=1", eip[0]); end
        expect_claim(0, 3);
        issue_claims(3'b001);
        n_cmp++; if (pending[3] !== 1'b0) begin n_err++; $display("FAIL lvl_claim_clr got=%b want=0", pending[3]); end
        step(1);
        n_cmp++; if (claim_vld !== '0) begin n_err++; $display("FAIL lvl_vld_pulse got=%b want=0", claim_vld); end
        n_cmp++; if (eip[0] !== 1'b0) begin n_err++; $display("FAIL lvl_eip_drop got=%b want=0", eip[0]); end
        step(3);
        n_cmp++; if (pending[3] !== 1'b0) begin n_err++; $display("FAIL lvl_no_repend got=%b want=0", pending[3]); end
        complete(0, 3);
        n_cmp++; if (pending[3] !== 1'b0) begin n_err++; $display("FAIL lvl_repend_early got=%b want=0", pending[3]); end
        step(1);
        n_cmp++; if (pending[3] !== 1'b1) begin n_err++; $display("FAIL lvl_repend got=%b want=1", pending[3]); end
        expect_claim(0, 3);
        issue_claims(3'b001);
        src_irq[2] = 1'b0;
        complete(0, 3);
        step(2);
    endtask

    task automatic test_back_to_back();
        set_prio(5, 4);
        set_prio(9, 4);
        set_en(0, 5);
        set_en(0, 9);
        src_irq[4] = 1'b1;
        src_irq[8] = 1'b1;
        step(2);
        expect_claim(0, 5);
        issue_claims(3'b001);
        expect_claim(0, 9);
        issue_claims(3'b001);
        src_irq[4] = 1'b0;
        src_irq[8] = 1'b0;
        complete(0, 5);
        complete(0, 9);
        step(2);
        n_cmp++; if (pending[9] !== 1'b0 || pending[5] !== 1'b0) begin n_err++; $display("FAIL tie_idle got=%b%b want=00", pending[5], pending[9]); end
    endtask

    task automatic test_threshold();
        set_prio(2, 3);
        set_en(0, 2);
        tgt_thresh[0 +: PW] = PW'(3);
        src_irq[1] = 1'b1;
        step(3);
        n_cmp++; if (pending[2] !== 1'b1) begin n_err++; $display("FAIL thr_pend got=%b want=1", pending[2]); end
        n_cmp++; if (eip[0] !== 1'b0) begin n_err++; $display("FAIL thr_eip_masked got=%b want=0", eip[0]); end
        tgt_thresh[0 +: PW] = PW'(2);
        step(1);
        n_cmp++; if (eip[0] !== 1'b1) begin n_err++; $display("FAIL thr_eip got=%b want=1", eip[0]); end
        expect_claim(0, 2);
        issue_claims(3'b001);
        src_irq[1] = 1'b0;
        complete(0, 2);
        tgt_thresh = '0;
        step(2);
    endtask

    task automatic test_edge();
        src_edge[6] = 1'b1;
        set_prio(7, 1);
        set_en(0, 7);
        src_irq[6] = 1'b1;
        step(1);
        n_cmp++; if (pending[7] !== 1'b1) begin n_err++; $display("FAIL edge_pend got=%b want=1", pending[7]); end
        src_irq[6] = 1'b0;
        step(1);
        for (int k = 0; k < 2; k++) begin
            src_irq[6] = 1'b1;
            step(1);
            src_irq[6] = 1'b0;
            step(1);
        end
        expect_claim(0, 7);
        issue_claims(3'b001);
        complete(0, 7);
        n_cmp++; if (pending[7] !== 1'b0) begin n_err++; $display("FAIL edge_early got=%b want=0", pending[7]); end
        step(1);
        n_cmp++; if (pending[7] !== 1'b1) begin n_err++; $display("FAIL edge_missed got=%b want=1", pending[7]); end
        expect_claim(0, 7);
        issue_claims(3'b001);
        complete(0, 7);
        step(3);
        n_cmp++; if (pending[7] !== 1'b0) begin n_err++; $display("FAIL edge_extra got=%b want=0", pending[7]); end
    endtask

    task automatic test_multi_target();
        set_prio(4, 3);
        set_en(0, 4);
        set_en(1, 4);
        src_irq[3] = 1'b1;
        step(2);
        n_cmp++; if (eip !== 3'b011) begin n_err++; $display("FAIL multi_eip got=%b want=011", eip); end
        expect_claim(0, 4);
        expect_claim(1, 0);
        issue_claims(3'b011);
        complete(2, 4);
        step(2);
        n_cmp++; if (pending[4] !== 1'b0) begin n_err++; $display("FAIL multi_bad_cmpl got=%b want=0", pending[4]); end
        complete(0, 4);
        step(1);
        n_cmp++; if (pending[4] !== 1'b1) begin n_err++; $display("FAIL multi_repend got=%b want=1", pending[4]); end
        expect_claim(2, 0);
        issue_claims(3'b100);
        n_cmp++; if (pending[4] !== 1'b1) begin n_err++; $display("FAIL multi_empty_claim got=%b want=1", pending[4]); end
        expect_claim(1, 4);
        issue_claims(3'b010);
        src_irq[3] = 1'b0;
        complete(1, 4);
        step(2);
        n_cmp++; if (pending[4] !== 1'b0) begin n_err++; $display("FAIL multi_idle got=%b want=0", pending[4]); end
    endtask

    task automatic test_reset_mid();
        src_irq[2] = 1'b1;
        step(2);
        expect_claim(0, 3);
        issue_claims(3'b001);
        rst = 1'b1;
        step(1);
        n_cmp++; if (pending !== '0) begin n_err++; $display("FAIL rmid_pending got=%h want=0", pending); end
        n_cmp++; if (eip !== '0) begin n_err++; $display("FAIL rmid_eip got=%b want=0", eip); end
        n_cmp++; if (claim_vld !== '0 || claim_id !== '0) begin n_err++; $display("FAIL rmid_claim got=%b/%h want=0/0", claim_vld, claim_id); end
        rst = 1'b0;
        step(1);
        n_cmp++; if (pending[3] !== 1'b1) begin n_err++; $display("FAIL rmid_repend got=%b want=1", pending[3]); end
        step(1);
        n_cmp++; if (eip[0] !== 1'b1) begin n_err++; $display("FAIL rmid_eip_after got=%b want=1", eip[0]); end
        expect_claim(0, 3);
        issue_claims(3'b001);
        src_irq[2] = 1'b0;
        complete(0, 3);
        step(2);
    endtask

    initial begin
        rst        = 1'b1;
        src_irq    = '0;
        src_edge   = '0;
        src_prio   = '0;
        tgt_en     = '0;
        tgt_thresh = '0;
        claim_req  = '0;
        cmpl_req   = '0;
        cmpl_id    = '0;
        test_reset();
        test_level();
        test_back_to_back();
        test_threshold();
        test_edge();
        test_multi_target();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Run-time bound so a stalled simulation still terminates.
    initial begin
        #200000;
        $display("FAIL timeout got=still running want=finished");
        $fatal(1, "timeout");
    end
endmodule
